// File: rtl/point_encode_pkg.sv
// point_encode_pkg: field constants and FSM states shared by the Ed25519 encode path.
package point_encode_pkg;
  localparam int FW = 255;
  localparam int MULT_LAT = 13;
  localparam logic [FW-1:0] P_MOD = {{247{1'b1}}, 8'hED};
  localparam logic [FW-1:0] P_MINUS_2 = {{247{1'b1}}, 8'hEB};
  typedef enum logic [2:0] {IDLE, INV, MULXY, CANON, OUTP, ERR} state_e;
endpackage

// File: rtl/point_encode_canon.sv
// fe_canon: reduces a value below 2^255 into [0, p).
module fe_canon
  import point_encode_pkg::*;
(
  input  logic [FW-1:0] a_i,
  output logic [FW-1:0] r_o
);
  assign r_o = (a_i >= P_MOD) ? a_i - P_MOD : a_i;
endmodule

// File: rtl/point_encode.sv
// point_encode: projective (X,Y,Z) to Ed25519 encoding via Fermat inversion on a shared multiplier.
module point_encode
  import point_encode_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          enc_start,
  input  logic [FW-1:0] enc_x_in,
  input  logic [FW-1:0] enc_y_in,
  input  logic [FW-1:0] enc_z_in,
  output logic          enc_ready,
  output logic          enc_mult_active,
  output logic [FW:0]   enc_mult_in_0,
  output logic [FW:0]   enc_mult_in_1,
  input  logic [FW-1:0] enc_mult_out,
  output logic          enc_done,
  output logic          enc_error,
  output logic [FW:0]   enc_point
);
  localparam logic [3:0] LAT = 4'(MULT_LAT);
  localparam logic [3:0] LAT1 = 4'(MULT_LAT + 1);
  state_e state_q, state_d;
  logic [FW-1:0] x_q, x_d, y_q, y_d, z_q, z_d, acc_q, acc_d, op_a, op_b, x_c, y_c;
  logic [7:0] k_q, k_d;
  logic [3:0] w_q, w_d;
  logic sq_q, sq_d, done_q, done_d, err_q, err_d;
  logic [FW:0] point_q, point_d;
  fe_canon u_canon_x (.a_i(x_q), .r_o(x_c));
  fe_canon u_canon_y (.a_i(y_q), .r_o(y_c));
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    acc_d = acc_q;
    k_d = k_q;
    w_d = w_q;
    sq_d = sq_q;
    done_d = 1'b0;
    err_d = 1'b0;
    point_d = point_q;
    op_a = '0;
    op_b = '0;
    case (state_q)
      IDLE: if (enc_start) begin
        x_d = enc_x_in;
        y_d = enc_y_in;
        z_d = enc_z_in;
        acc_d = enc_z_in;
        k_d = 8'd253;
        sq_d = 1'b1;
        w_d = '0;
        state_d = (enc_z_in == '0 || enc_z_in == P_MOD) ? ERR : INV;
      end
      // square-and-multiply, MSB first; each op waits out the full multiplier latency
      INV: begin
        w_d = w_q + 4'd1;
        op_a = (w_q == '0) ? acc_q : '0;
        op_b = (w_q == '0) ? (sq_q ? acc_q : z_q) : '0;
        if (w_q == LAT) begin
          acc_d = enc_mult_out;
          w_d = '0;
          if (sq_q && P_MINUS_2[k_q]) sq_d = 1'b0;
          else begin
            sq_d = 1'b1;
            k_d = k_q - 8'd1;
            if (k_q == '0) state_d = MULXY;
          end
        end
      end
      MULXY: begin
        w_d = w_q + 4'd1;
        op_a = (w_q == 4'd0) ? x_q : (w_q == 4'd1) ? y_q : '0;
        op_b = (w_q < 4'd2) ? acc_q : '0;
        if (w_q == LAT) x_d = enc_mult_out;
        if (w_q == LAT1) begin
          y_d = enc_mult_out;
          state_d = CANON;
        end
      end
      CANON: begin
        point_d = {x_c[0], y_c};
        done_d = 1'b1;
        state_d = OUTP;
      end
      OUTP: state_d = IDLE;
      ERR: begin
        point_d = '0;
        done_d = 1'b1;
        err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      acc_q <= '0;
      k_q <= '0;
      w_q <= '0;
      sq_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      point_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      acc_q <= acc_d;
      k_q <= k_d;
      w_q <= w_d;
      sq_q <= sq_d;
      done_q <= done_d;
      err_q <= err_d;
      point_q <= point_d;
    end
  end
  assign enc_ready = state_q == IDLE;
  assign enc_mult_active = state_q == INV || state_q == MULXY;
  assign enc_mult_in_0 = {1'b0, op_a};
  assign enc_mult_in_1 = {1'b0, op_b};
  assign enc_done = done_q;
  assign enc_error = err_q;
  assign enc_point = point_q;
endmodule
